// File: rtl/alu_issue_station_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_station_pkg
//   Shared widths, entry record types and the writeback-bypass lookup used by
//   the ALU reservation station.
//
//   Widths mirror the processor-wide definitions: ROB tag width, ALU op /
//   control / compare / exception field widths, and the default station depth.
// ---------------------------------------------------------------------------
package alu_issue_station_pkg;

    localparam int ROB_SIZE      = 32;
    localparam int TAG_W         = $clog2(ROB_SIZE);
    localparam int CNT_ALUOP     = 5;
    localparam int CNT_CTRL      = 8;
    localparam int CTRL_wen      = 0;
    localparam int CNT_CMP       = 3;
    localparam int CNT_EXCEPTION = 5;
    localparam int ALU_RS_DEPTH  = 4;

    // Operand-independent part of a buffered micro-op.
    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              inst;
        logic [31:0]              predict_target;
        logic [CNT_ALUOP-1:0]     aluop;
        logic [CNT_CTRL-1:0]      ctrl;
        logic [CNT_CMP-1:0]       cmpop;
        logic [CNT_EXCEPTION-1:0] excode;
        logic                     predict;
        logic [TAG_W-1:0]         destnum;
    } payload_t;

    // One source operand: have=1 means val is valid, otherwise wait on num.
    typedef struct packed {
        logic             have;
        logic [TAG_W-1:0] num;
        logic [31:0]      val;
    } operand_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } bypass_t;

    // Tag match against the three writeback buses; wb0 beats wb1 beats mu.
    function automatic bypass_t bypass_lookup(
        input logic [TAG_W-1:0] tag,
        input logic             wb0_en,
        input logic [TAG_W-1:0] wb0_num,
        input logic [31:0]      wb0_data,
        input logic             wb1_en,
        input logic [TAG_W-1:0] wb1_num,
        input logic [31:0]      wb1_data,
        input logic             mu_en,
        input logic [TAG_W-1:0] mu_num,
        input logic [31:0]      mu_data
    );
        bypass_t r;
        r.hit  = 1'b0;
        r.data = '0;
        // Lowest priority first so higher-priority matches overwrite.
        if (mu_en && (mu_num == tag)) begin
            r.hit  = 1'b1;
            r.data = mu_data;
        end
        if (wb1_en && (wb1_num == tag)) begin
            r.hit  = 1'b1;
            r.data = wb1_data;
        end
        if (wb0_en && (wb0_num == tag)) begin
            r.hit  = 1'b1;
            r.data = wb0_data;
        end
        return r;
    endfunction

    // Apply a bypass hit to a waiting operand (WAIT -> HAVE with data capture).
    function automatic operand_t operand_snoop(input operand_t op, input bypass_t b);
        operand_t r;
        r = op;
        if (!op.have && b.hit) begin
            r.have = 1'b1;
            r.val  = b.data;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// ---------------------------------------------------------------------------
// alu_rs_pick
//   Lowest-index priority picker for the ALU reservation station.
//   Ports:
//     req   [DEPTH-1:0]  per-entry selectable flags (index 0 = oldest)
//     grant [DEPTH-1:0]  one-hot of the lowest set request bit (0 if none)
//     idx   [IDX_W-1:0]  binary index of that bit (0 if none)
// ---------------------------------------------------------------------------
module alu_rs_pick #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    // Scan from the youngest down so the oldest request is the last to win.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_issue_station.sv
// ---------------------------------------------------------------------------
// alu_issue_station
//   ALU reservation station feeding the ALU FU sel_* issue bundle.
//   Collapsing queue (index 0 oldest) of DEPTH entries with registered count.
//   Operands are tracked by ROB tag and captured from the wb0/wb1/mu bypasses;
//   the oldest entry with both operands available is presented combinationally
//   on sel_* and, because the FU always latches it, is removed on the next edge.
//
//   Ports:
//     clk, resetn (async active-low), flush
//     disp_*  dispatch handshake + micro-op payload + operand tags/values
//     wk0/wk1 execute-stage wakeups, wb0/wb1/mu writeback bypasses
//     sel_*   issue bundle to the FU
//
//   Build option: ALU_RS_SPEC_WAKEUP_EN -- when defined, a wk0/wk1 tag match
//   makes a waiting operand selectable (value resolved by the FU next cycle).
//   When undefined the wk* ports are ignored.
// ---------------------------------------------------------------------------
module alu_issue_station
    import alu_issue_station_pkg::*;
#(
    parameter int DEPTH = ALU_RS_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [31:0]              disp_PC,
    input  logic [31:0]              disp_inst,
    input  logic [31:0]              disp_predict_target,
    input  logic [CNT_ALUOP-1:0]     disp_aluop,
    input  logic [CNT_CTRL-1:0]      disp_ctrl,
    input  logic [CNT_CMP-1:0]       disp_cmpop,
    input  logic [CNT_EXCEPTION-1:0] disp_excode,
    input  logic                     disp_predict,
    input  logic [TAG_W-1:0]         disp_rsnum,
    input  logic [TAG_W-1:0]         disp_rtnum,
    input  logic [TAG_W-1:0]         disp_destnum,
    input  logic [31:0]              disp_rsval,
    input  logic [31:0]              disp_rtval,
    input  logic                     disp_rs_ready,
    input  logic                     disp_rt_ready,
    input  logic                     wk0_en,
    input  logic [TAG_W-1:0]         wk0_num,
    input  logic                     wk1_en,
    input  logic [TAG_W-1:0]         wk1_num,
    input  logic                     wb0_en,
    input  logic [TAG_W-1:0]         wb0_num,
    input  logic [31:0]              wb0_data,
    input  logic                     wb1_en,
    input  logic [TAG_W-1:0]         wb1_num,
    input  logic [31:0]              wb1_data,
    input  logic                     mu_en,
    input  logic [TAG_W-1:0]         mu_num,
    input  logic [31:0]              mu_data,
    output logic                     sel_valid,
    output logic [31:0]              sel_PC,
    output logic [31:0]              sel_inst,
    output logic [CNT_ALUOP-1:0]     sel_aluop,
    output logic [CNT_CTRL-1:0]      sel_ctrl,
    output logic [CNT_CMP-1:0]       sel_cmpop,
    output logic [CNT_EXCEPTION-1:0] sel_excode,
    output logic                     sel_predict,
    output logic [31:0]              sel_predict_target,
    output logic [TAG_W-1:0]         sel_rsnum,
    output logic [TAG_W-1:0]         sel_rtnum,
    output logic [31:0]              sel_rsval,
    output logic [31:0]              sel_rtval,
    output logic                     sel_rsval_ready,
    output logic                     sel_rtval_ready,
    output logic [TAG_W-1:0]         sel_destnum
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    // State
    logic [DEPTH-1:0] valid_q,   valid_d;
    payload_t         payload_q [DEPTH];
    payload_t         payload_d [DEPTH];
    operand_t         rs_q      [DEPTH];
    operand_t         rs_d      [DEPTH];
    operand_t         rt_q      [DEPTH];
    operand_t         rt_d      [DEPTH];
    logic [CNT_W-1:0] count_q,   count_d;

    // Per-entry bypass view
    bypass_t          rs_byp    [DEPTH];
    bypass_t          rt_byp    [DEPTH];
    operand_t         rs_upd    [DEPTH];
    operand_t         rt_upd    [DEPTH];
    logic [DEPTH-1:0] rs_wk, rt_wk;
    logic [DEPTH-1:0] ready_vec;

    logic [DEPTH-1:0] pick_grant;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;

    // New-entry view
    payload_t         disp_payload;
    bypass_t          disp_rs_byp, disp_rt_byp;
    operand_t         disp_rs_op,  disp_rt_op;
    logic             disp_acc;
    logic [IDX_W-1:0] wr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign rs_byp[gi] = bypass_lookup(rs_q[gi].num,
                                              wb0_en, wb0_num, wb0_data,
                                              wb1_en, wb1_num, wb1_data,
                                              mu_en,  mu_num,  mu_data);
            assign rt_byp[gi] = bypass_lookup(rt_q[gi].num,
                                              wb0_en, wb0_num, wb0_data,
                                              wb1_en, wb1_num, wb1_data,
                                              mu_en,  mu_num,  mu_data);
            assign rs_upd[gi] = operand_snoop(rs_q[gi], rs_byp[gi]);
            assign rt_upd[gi] = operand_snoop(rt_q[gi], rt_byp[gi]);
`ifdef ALU_RS_SPEC_WAKEUP_EN
            assign rs_wk[gi] = (wk0_en && (wk0_num == rs_q[gi].num)) ||
                               (wk1_en && (wk1_num == rs_q[gi].num));
            assign rt_wk[gi] = (wk0_en && (wk0_num == rt_q[gi].num)) ||
                               (wk1_en && (wk1_num == rt_q[gi].num));
`else
            assign rs_wk[gi] = 1'b0;
            assign rt_wk[gi] = 1'b0;
`endif
            // rs_upd.have already folds in a same-cycle WB/MU hit.
            assign ready_vec[gi] = valid_q[gi] &
                                   (rs_upd[gi].have | rs_wk[gi]) &
                                   (rt_upd[gi].have | rt_wk[gi]);
        end
    endgenerate

`ifndef ALU_RS_SPEC_WAKEUP_EN
    // Wakeup ports have no function in this build.
    logic unused_wk;
    assign unused_wk = ^{wk0_en, wk0_num, wk1_en, wk1_num};
`endif

    alu_rs_pick #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (ready_vec),
        .grant (pick_grant),
        .idx   (sel_idx)
    );

    // Presented entry counts as issued; flush suppresses it.
    assign issue      = (|pick_grant) & ~flush;
    assign disp_ready = (count_q < CNT_W'(DEPTH)) & ~flush;
    assign disp_acc   = disp_valid & disp_ready;

    // ------------------------------------------------------------------
    // Issue bundle
    // ------------------------------------------------------------------
    always_comb begin
        sel_valid          = issue;
        sel_PC             = '0;
        sel_inst           = '0;
        sel_aluop          = '0;
        sel_ctrl           = '0;
        sel_cmpop          = '0;
        sel_excode         = '0;
        sel_predict        = 1'b0;
        sel_predict_target = '0;
        sel_rsnum          = '0;
        sel_rtnum          = '0;
        sel_rsval          = '0;
        sel_rtval          = '0;
        sel_rsval_ready    = 1'b0;
        sel_rtval_ready    = 1'b0;
        sel_destnum        = '0;
        if (issue) begin
            sel_PC             = payload_q[sel_idx].pc;
            sel_inst           = payload_q[sel_idx].inst;
            sel_aluop          = payload_q[sel_idx].aluop;
            sel_ctrl           = payload_q[sel_idx].ctrl;
            sel_cmpop          = payload_q[sel_idx].cmpop;
            sel_excode         = payload_q[sel_idx].excode;
            sel_predict        = payload_q[sel_idx].predict;
            sel_predict_target = payload_q[sel_idx].predict_target;
            sel_destnum        = payload_q[sel_idx].destnum;
            sel_rsnum          = rs_q[sel_idx].num;
            sel_rtnum          = rt_q[sel_idx].num;
            // A wakeup-only operand goes out with value 0 / ready 0 and the
            // FU picks it up from its own bypass next cycle.
            if (rs_upd[sel_idx].have) begin
                sel_rsval       = rs_upd[sel_idx].val;
                sel_rsval_ready = 1'b1;
            end
            if (rt_upd[sel_idx].have) begin
                sel_rtval       = rt_upd[sel_idx].val;
                sel_rtval_ready = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch record, with same-cycle bypass snoop
    // ------------------------------------------------------------------
    assign disp_payload = '{
        pc:             disp_PC,
        inst:           disp_inst,
        predict_target: disp_predict_target,
        aluop:          disp_aluop,
        ctrl:           disp_ctrl,
        cmpop:          disp_cmpop,
        excode:         disp_excode,
        predict:        disp_predict,
        destnum:        disp_destnum
    };
    assign disp_rs_byp = bypass_lookup(disp_rsnum,
                                       wb0_en, wb0_num, wb0_data,
                                       wb1_en, wb1_num, wb1_data,
                                       mu_en,  mu_num,  mu_data);
    assign disp_rt_byp = bypass_lookup(disp_rtnum,
                                       wb0_en, wb0_num, wb0_data,
                                       wb1_en, wb1_num, wb1_data,
                                       mu_en,  mu_num,  mu_data);
    assign disp_rs_op  = operand_snoop('{have: disp_rs_ready, num: disp_rsnum, val: disp_rsval},
                                       disp_rs_byp);
    assign disp_rt_op  = operand_snoop('{have: disp_rt_ready, num: disp_rtnum, val: disp_rtval},
                                       disp_rt_byp);

    // Append slot is computed after the issued entry collapses out.
    assign wr_idx = IDX_W'(count_q - CNT_W'(issue));

    // ------------------------------------------------------------------
    // Next state: collapse, snoop, append, flush
    // ------------------------------------------------------------------
    always_comb begin
        logic       shift;
        logic [IDX_W-1:0] src;
        valid_d = '0;
        count_d = count_q + CNT_W'(disp_acc) - CNT_W'(issue);
        for (int j = 0; j < DEPTH; j++) begin
            shift = issue && (IDX_W'(j) >= sel_idx);
            src   = (shift && (j < DEPTH - 1)) ? IDX_W'(j + 1) : IDX_W'(j);
            valid_d[j]   = valid_q[src] & ~(shift && (j == DEPTH - 1));
            payload_d[j] = payload_q[src];
            rs_d[j]      = rs_upd[src];
            rt_d[j]      = rt_upd[src];
        end
        if (disp_acc) begin
            valid_d[wr_idx]   = 1'b1;
            payload_d[wr_idx] = disp_payload;
            rs_d[wr_idx]      = disp_rs_op;
            rt_d[wr_idx]      = disp_rt_op;
        end
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= '0;
                rs_q[i]      <= '0;
                rt_q[i]      <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= payload_d[i];
                rs_q[i]      <= rs_d[i];
                rt_q[i]      <= rt_d[i];
            end
        end
    end

endmodule

// File: doc/alu_issue_station.md
Name: alu_issue_station

Overview:
- ALU reservation station: the producer side of the ALU functional unit's `sel_*` issue interface.
- Buffers dispatched ALU micro-ops and tracks operand readiness by ROB tag.
- Snoops writeback bypasses and execute-stage wakeups, and presents the oldest selectable entry each cycle.
- The FU latches `sel_*` every cycle unconditionally, so a presented entry counts as issued.

Parameters:
- DEPTH, 4, number of station entries (power of two not required, 2..8).

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, asynchronous active-low
- `flush`  in  1  commit-side pipeline flush
- `disp_valid`  in  1  dispatch request
- `disp_ready`  out  1  station can accept
- `disp_PC`, `disp_inst`, `disp_predict_target`  in  32 each  payload
- `disp_aluop`, `disp_ctrl`, `disp_cmpop`, `disp_excode`, `disp_predict`  in  defs.h widths  payload
- `disp_rsnum`, `disp_rtnum`, `disp_destnum`  in  $clog2(`ROB_SIZE)  operand/dest tags
- `disp_rsval`, `disp_rtval`  in  32  operand values
- `disp_rs_ready`, `disp_rt_ready`  in  1  value valid at dispatch
- `wk0_en`/`wk0_num`, `wk1_en`/`wk1_num`  in  1/tag  execute-stage wakeups from ALU0/ALU1
- `wb0_en`/`wb0_num`/`wb0_data`, `wb1_en`/`wb1_num`/`wb1_data`, `mu_en`/`mu_num`/`mu_data`  in  1/tag/32  writeback bypasses
- `sel_*`  out  the FU issue bundle:
  - `sel_valid`, `sel_PC`, `sel_inst`, `sel_aluop`, `sel_ctrl`, `sel_cmpop`, `sel_excode`, `sel_predict`, `sel_predict_target`
  - `sel_rsnum`, `sel_rtnum`, `sel_rsval`, `sel_rtval`, `sel_rsval_ready`, `sel_rtval_ready`, `sel_destnum`

Behaviour:
- Storage: collapsing queue, index 0 oldest; registered count.
- Reset (async, `resetn`=0): all entries invalid, count=0.
  - Outputs: `disp_ready`=1, `sel_valid`=0, all `sel_*` payload 0.
- `disp_ready` = (count<DEPTH) & ~`flush`, from registered count only; same-cycle issue does not free space.
- Dispatch accepted when `disp_valid` & `disp_ready`.
  - Entry is appended at index count, after collapse of the issued entry.
  - Same-cycle WB snoop is applied to the new entry's operands.
  - A new entry is never selectable in its dispatch cycle.
- Operand states per entry: HAVE (value stored) or WAIT (tag stored).
  - WAIT→HAVE when any `wbX_en`/`mu_en` tag matches; data is captured.
  - Priority on multiple matches: `wb0` > `wb1` > `mu`.
- An operand is selectable in a cycle if it is:
  - HAVE → `sel_*val` = stored value, `sel_*val_ready`=1;
  - WAIT with a same-cycle WB/MU tag match → `sel_*val` = bypass data, `sel_*val_ready`=1;
  - WAIT with a `wk0`/`wk1` tag match (only under the optional feature) → `sel_*val` = 0, `sel_*val_ready`=0, `sel_*num` = tag; the FU resolves it next cycle.
- Select: lowest-index entry with both operands selectable; outputs are combinational.
  - `sel_valid`=1 when any entry is selectable.
  - On the next edge that entry is removed and younger entries shift down one.
- Simultaneous issue and dispatch: count unchanged; the new entry lands at index count-1.
- Full: `disp_ready`=0; dispatch is ignored even if issue frees a slot that cycle.
- `flush`:
  - `sel_valid` is forced 0 combinationally.
  - On the edge all entries are invalidated and count=0.
  - Dispatch in the flush cycle is dropped.
- Wakeup is one-shot. An entry woken but not selected is not held as ready; it captures the WB bypass the following cycle instead.

Optional Feature:
- Macro: `ALU_RS_SPEC_WAKEUP_EN`.
- Defined: `wk0`/`wk1` matches make WAIT operands selectable, giving back-to-back dependent ALU issue.
- Undefined: `wk*` ports are ignored. Dependents issue only on the WB match cycle or later, adding one bubble.

Decomposition:
- Constants and widths come from the shared `defs.h`:
  - `ROB_SIZE`, `CNT_ALUOP`, `CNT_CTRL`, `CTRL_wen`, `CNT_CMP`, `CNT_EXCEPTION`;
  - new `ALU_RS_DEPTH` default.
- Sub-module `alu_rs_pick`: a DEPTH-wide ready vector in, one-hot and index of the lowest set bit out.

Test Plan:
- Reset then dispatch ADD with both operands ready, rsval=5, rtval=7 → next cycle `sel_valid`=1, `sel_rsval`=5, `sel_rtval`=7, both ready=1; following cycle station is empty.
- Dispatch entry waiting rs tag 3, then drive `wb1_en`=1, `wb1_num`=3, `wb1_data`=0x1234 → same cycle `sel_valid`=1, `sel_rsval`=0x1234, `sel_rsval_ready`=1.
- With `ALU_RS_SPEC_WAKEUP_EN` and rs tag 6, pulse `wk0_en`, `wk0_num`=6 → `sel_valid`=1, `sel_rsval_ready`=0, `sel_rsnum`=6. Without the macro → `sel_valid`=0 that cycle, then 1 next cycle when `wb0` tag 6 arrives.
- Fill 4 entries, none ready → `disp_ready`=0. Wake entry 2 → entry 2 issues; next cycle count=3 and entry 3 occupies index 2.
- Two ready entries A (older) and B → A issues first, B the next cycle.
- Station holds 3 entries, assert `flush` with `disp_valid`=1 → `sel_valid`=0; next cycle count=0, `disp_ready`=1. Assert `resetn`=0 mid-operation → outputs reset immediately without waiting for a clock edge.
